// File: rtl/id_ex_pkg.sv
// Shared defaults and state type for the ID/EX pipeline register stage.
package id_ex_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } id_ex_state_e;

    // Bubble counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'h0001;
        end
        return result;
    endfunction

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use hazard detect: the load sitting in EX targets a source of the decode slot.
module id_ex_hazard
    import id_ex_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              in_run,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [ADDR_W-1:0] ex_rd,
    output logic              load_use
);

    // Register 0 compares like any other register number.
    assign load_use = in_run && id_valid && ex_valid && ex_mem_read && ex_reg_write &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and bubble counter.
// Optional write-back bypass of operands: define ID_EX_WB_BYPASS_EN.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [ADDR_W-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [15:0]       bubble_cnt
);

    id_ex_state_e      state_r;
    logic              load_use_s;
    logic [DATA_W-1:0] op1_s;
    logic [DATA_W-1:0] op2_s;
    logic [15:0]       bubble_cnt_nxt_s;
    logic              wb_unused_s;

    id_ex_hazard #(.ADDR_W(ADDR_W)) u_hazard (
        .in_run       (state_r == ST_RUN),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_rd        (ex_rd),
        .load_use     (load_use_s)
    );

    assign id_ready    = ex_ready && !load_use_s;
    assign wb_unused_s = ^{wb_reg_write, wb_reg, wb_data};

    // Operand selection for the decode slot.
    always_comb begin
        op1_s = rf_rd1;
        op2_s = rf_rd2;
`ifdef ID_EX_WB_BYPASS_EN
        if (wb_reg_write && (wb_reg == id_rs1)) begin
            op1_s = wb_data;
        end else begin
            op1_s = rf_rd1;
        end
        if (wb_reg_write && (wb_reg == id_rs2)) begin
            op2_s = wb_data;
        end else begin
            op2_s = rf_rd2;
        end
`endif
    end

    // Bubble counter next value; flush suppresses the RUN->BUBBLE edge.
    always_comb begin
        bubble_cnt_nxt_s = bubble_cnt;
        if (!flush && ex_ready && load_use_s) begin
            bubble_cnt_nxt_s = sat_inc16(bubble_cnt);
        end else begin
            bubble_cnt_nxt_s = bubble_cnt;
        end
    end

    // Bubble counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= 16'h0000;
        end else begin
            bubble_cnt <= bubble_cnt_nxt_s;
        end
    end

    // EX payload and RUN/BUBBLE state; flush beats stall, bubble and transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_RUN;
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_op1       <= {DATA_W{1'b0}};
            ex_op2       <= {DATA_W{1'b0}};
            ex_rd        <= {ADDR_W{1'b0}};
        end else if (flush) begin
            state_r      <= ST_RUN;
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
        end else if (ex_ready) begin
            if (load_use_s) begin
                state_r      <= ST_BUBBLE;
                ex_valid     <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
            end else begin
                state_r <= ST_RUN;
                if (id_valid) begin
                    ex_valid     <= 1'b1;
                    ex_reg_write <= id_reg_write;
                    ex_mem_read  <= id_mem_read;
                    ex_op1       <= op1_s;
                    ex_op2       <= op2_s;
                    ex_rd        <= id_rd;
                end else begin
                    ex_valid     <= 1'b0;
                    ex_reg_write <= 1'b0;
                    ex_mem_read  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a cycle-level reference model.
module tb_id_ex_stage;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic          id_ready;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_reg_write, id_mem_read;
    logic [DW-1:0] rf_rd1, rf_rd2;
    logic          wb_reg_write;
    logic [AW-1:0] wb_reg;
    logic [DW-1:0] wb_data;
    logic          flush, ex_ready;
    logic          ex_valid;
    logic [DW-1:0] ex_op1, ex_op2;
    logic [AW-1:0] ex_rd;
    logic          ex_reg_write, ex_mem_read;
    logic [15:0]   bubble_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: what EX should hold, and whether a bubble was just inserted.
    bit            m_valid, m_rw, m_mr, m_in_bubble;
    logic [DW-1:0] m_op1, m_op2;
    logic [AW-1:0] m_rd;
    logic [15:0]   m_cnt;

    id_ex_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_reg_write(wb_reg_write), .wb_reg(wb_reg), .wb_data(wb_data),
        .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_hazard();
        return !m_in_bubble && id_valid && m_valid && m_mr && m_rw &&
               (m_rd == id_rs1 || m_rd == id_rs2);
    endfunction

    function automatic logic [DW-1:0] model_operand(input logic [AW-1:0] rs, input logic [DW-1:0] rf);
`ifdef ID_EX_WB_BYPASS_EN
        if (wb_reg_write && wb_reg == rs) return wb_data;
`endif
        return rf;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_in_bubble = 0;
        m_op1 = '0; m_op2 = '0; m_rd = '0; m_cnt = 16'h0000;
    endtask

    task automatic model_edge();
        bit hz;
        hz = model_hazard();
        if (flush) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_in_bubble = 0;
        end else if (ex_ready) begin
            if (hz) begin
                m_valid = 0; m_rw = 0; m_mr = 0; m_in_bubble = 1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end else begin
                m_in_bubble = 0;
                m_valid = id_valid;
                if (id_valid) begin
                    m_rw = id_reg_write; m_mr = id_mem_read; m_rd = id_rd;
                    m_op1 = model_operand(id_rs1, rf_rd1);
                    m_op2 = model_operand(id_rs2, rf_rd2);
                end else begin
                    m_rw = 0; m_mr = 0;
                end
            end
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
        chk({tag, ".rw"},    32'(ex_reg_write), 32'(m_rw));
        chk({tag, ".mr"},    32'(ex_mem_read), 32'(m_mr));
        chk({tag, ".op1"},   32'(ex_op1), 32'(m_op1));
        chk({tag, ".op2"},   32'(ex_op2), 32'(m_op2));
        chk({tag, ".rd"},    32'(ex_rd), 32'(m_rd));
        chk({tag, ".cnt"},   32'(bubble_cnt), 32'(m_cnt));
    endtask

    task automatic set_in(input bit v, input int rs1, input int rs2, input int rd,
                          input bit rw, input bit mr, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input bit fl, input bit er);
        id_valid = v; id_rs1 = AW'(rs1); id_rs2 = AW'(rs2); id_rd = AW'(rd);
        id_reg_write = rw; id_mem_read = mr; rf_rd1 = d1; rf_rd2 = d2;
        flush = fl; ex_ready = er;
    endtask

    // One clock: check id_ready, clock the DUT and model, then check EX outputs.
    task automatic cycle(input string tag);
        #1;
        chk({tag, ".id_ready"}, 32'(id_ready), 32'(ex_ready && !model_hazard()));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outs(tag);
    endtask

    initial begin
        logic [DW-1:0] exp_byp;
        logic [DW-1:0] snap_op1;
        rst_n = 1'b0;
        wb_reg_write = 1'b0; wb_reg = '0; wb_data = '0;
        set_in(0, 0, 0, 0, 0, 0, '0, '0, 0, 1);
        model_reset();
        #2;
        check_outs("reset");
        chk("reset.id_ready", 32'(id_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // plain transfer
        set_in(1, 2, 0, 1, 1, 0, 16'h1234, 16'h0055, 0, 1);
        cycle("xfer");
        chk("xfer.op1_direct", 32'(ex_op1), 32'h1234);

        // load-use: load rd=5 in EX, consumer reads rs2=5
        set_in(1, 0, 0, 5, 1, 1, 16'h0001, 16'h0002, 0, 1);
        cycle("lu_load");
        set_in(1, 7, 5, 6, 1, 0, 16'h00A0, 16'h00B0, 0, 1);
        #1 chk("lu.id_ready_low", 32'(id_ready), 32'd0);
        cycle("lu_bubble");
        chk("lu.bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu.bubble_cnt", 32'(bubble_cnt), 32'd1);
        cycle("lu_xfer");
        chk("lu.xfer_rd", 32'(ex_rd), 32'd6);

        // write-back bypass
        wb_reg_write = 1'b1; wb_reg = 4'd3; wb_data = 16'hBEEF;
        set_in(1, 3, 0, 2, 1, 0, 16'h0000, 16'h0011, 0, 1);
        cycle("bypass");
`ifdef ID_EX_WB_BYPASS_EN
        exp_byp = 16'hBEEF;
`else
        exp_byp = 16'h0000;
`endif
        chk("bypass.op1_direct", 32'(ex_op1), 32'(exp_byp));
        wb_reg_write = 1'b0;

        // hold three cycles with changing decode inputs
        snap_op1 = ex_op1;
        for (int i = 0; i < 3; i++) begin
            set_in(1, i, i + 1, 9, 1, 1, DW'($urandom), DW'($urandom), 0, 0);
            cycle("hold");
            chk("hold.op1_const", 32'(ex_op1), 32'(snap_op1));
        end

        // flush during a bubble-causing hazard
        set_in(1, 0, 0, 4, 1, 1, 16'h0F0F, 16'h0000, 0, 1);
        cycle("fl_load");
        set_in(1, 4, 0, 8, 1, 0, 16'h0000, 16'h0000, 1, 1);
        cycle("flush");
        chk("flush.valid_direct", 32'(ex_valid), 32'd0);
        chk("flush.state", 32'(dut.state_r), 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            wb_reg_write = 1'($urandom); wb_reg = AW'($urandom_range(0, 3));
            wb_data = DW'($urandom);
            set_in(($urandom % 4) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), ($urandom % 4) != 0, ($urandom % 2) != 0,
                   DW'($urandom), DW'($urandom), ($urandom % 16) == 0, ($urandom % 4) != 0);
            cycle("rand");
        end
        wb_reg_write = 1'b0;

        // reset asserted mid-stall, between clock edges
        set_in(1, 0, 0, 5, 1, 1, 16'h00C3, 16'h0000, 0, 1);
        cycle("rs_load");
        set_in(1, 5, 0, 7, 1, 0, 16'h0000, 16'h0000, 0, 1);
        cycle("rs_bubble");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_outs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset.state", 32'(dut.state_r), 32'd0);
        cycle("after_reset");

        // saturation: preload the counter to FFFE, then two load-use events
        set_in(0, 0, 0, 0, 0, 0, '0, '0, 0, 1);
        force dut.bubble_cnt_nxt_s = 16'hFFFE;
        @(posedge clk);
        model_edge();
        m_cnt = 16'hFFFE;
        #1 release dut.bubble_cnt_nxt_s;
        @(negedge clk);
        check_outs("preload");
        set_in(1, 0, 0, 5, 1, 1, 16'h0001, 16'h0000, 0, 1);
        cycle("sat_load");
        set_in(1, 5, 1, 5, 1, 1, 16'h0002, 16'h0000, 0, 1);
        cycle("sat_bub1");
        cycle("sat_x1");
        cycle("sat_bub2");
        chk("sat.cnt_direct", 32'(bubble_cnt), 32'hFFFF);
        cycle("sat_x2");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
